ram_arbiter: RTL and testbench

Single-cycle arbiter that shares the single-port program/data RAM (`top.ram`) between the ktc32 core's instruction-fetch port and its load/store port. It grants at most one request per cycle and routes the RAM's one-cycle-latency read data back to the owner. A fairness counter bounds instruction-fetch starvation. An optional loader port writes program images over a serial loader instead of `$readmemh`.

---
 rtl/ktc32_mem_pkg.sv | 19 +
 rtl/ram_arb_prio.sv | 29 ++
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ktc32_mem_pkg.sv
// rtl/ktc32_mem_pkg.sv - shared memory-side types and default widths for the ktc32 RAM path
package ktc32_mem_pkg;

  localparam int KTC32_ADDR_W = 14;
  localparam int KTC32_DATA_W = 32;

  // Bit positions inside the one-hot grant vector from ram_arb_prio
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;
  localparam int GNT_L = 2;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_INSTR  = 2'd1,
    OWN_DATA   = 2'd2,
    OWN_LOADER = 2'd3
  } owner_e;

endpackage

// File: rtl/ram_arb_prio.sv
// rtl/ram_arb_prio.sv - combinational one-hot priority pick (loader > starved fetch > data > fetch)
// Loader requester present only when KTC32_LOADER_EN is defined.
module ram_arb_prio
  import ktc32_mem_pkg::*;
(
`ifdef KTC32_LOADER_EN
  input  logic       l_req,
`endif
  input  logic       d_req,
  input  logic       i_req,
  input  logic       starve,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
`ifdef KTC32_LOADER_EN
    if (l_req) begin
      gnt[GNT_L] = 1'b1;
    end else
`endif
    if (i_req && (starve || !d_req)) begin
      gnt[GNT_I] = 1'b1;
    end else if (d_req) begin
      gnt[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter for ktc32 fetch/load-store ports with starvation bound
// Optional serial-loader write port compiled in with KTC32_LOADER_EN.
module ram_arbiter
  import ktc32_mem_pkg::*;
#(
  parameter int ADDR_W       = KTC32_ADDR_W,
  parameter int DATA_W       = KTC32_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
`ifdef KTC32_LOADER_EN
  input  logic                l_req,
  input  logic [ADDR_W-1:0]   l_addr,
  input  logic [DATA_W-1:0]   l_wdata,
  output logic                l_gnt,
`endif
  output logic                ram_en,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  logic [3:0] starve_cnt;
  logic       starve;
  logic [2:0] gnt;
  owner_e     rd_owner;
  owner_e     owner_next;

  assign starve = (starve_cnt == 4'(STARVE_LIMIT));

  // Requests are masked during reset so grants and RAM strobes stay low
  ram_arb_prio u_prio (
`ifdef KTC32_LOADER_EN
    .l_req  (l_req & ~reset),
`endif
    .d_req  (d_req & ~reset),
    .i_req  (i_req & ~reset),
    .starve (starve),
    .gnt    (gnt)
  );

  assign i_gnt = gnt[GNT_I];
  assign d_gnt = gnt[GNT_D];
`ifdef KTC32_LOADER_EN
  assign l_gnt = gnt[GNT_L];
`endif

  always_comb begin
    ram_en     = |gnt;
    ram_we     = 1'b0;
    ram_be     = '1;
    ram_addr   = i_addr;
    ram_wdata  = d_wdata;
    owner_next = OWN_NONE;
`ifdef KTC32_LOADER_EN
    if (gnt[GNT_L]) begin
      ram_we    = 1'b1;
      ram_addr  = l_addr;
      ram_wdata = l_wdata;
    end else
`endif
    if (gnt[GNT_D]) begin
      ram_we   = d_we;
      ram_be   = d_be;
      ram_addr = d_addr;
      if (!d_we) owner_next = OWN_DATA;
    end else if (gnt[GNT_I]) begin
      owner_next = OWN_INSTR;
    end
  end

  // Saturating count of data grants taken while a fetch is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && !starve) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_owner <= OWN_NONE;
    else       rd_owner <= owner_next;
  end

  assign i_rvalid = (rd_owner == OWN_INSTR);
  assign d_rvalid = (rd_owner == OWN_DATA);
  assign i_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (loader checks under KTC32_LOADER_EN)
module tb_ram_arbiter;
  import ktc32_mem_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          ram_en, ram_we;
  logic [BW-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef KTC32_LOADER_EN
  logic          l_req, l_gnt;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef KTC32_LOADER_EN
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
`endif
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Byte-enabled single-port RAM with one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          instr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic push_exp(input logic instr, input logic [DW-1:0] data);
    exp_t e;
    e.instr = instr;
    e.data  = data;
    sbq.push_back(e);
  endtask

  // Read-return monitor: every rvalid must match the oldest expected read
  always @(posedge clk) begin
    #3;
    if (i_rvalid || d_rvalid) begin
      if (sbq.size() == 0) begin
        check("rv_unexpected", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rv_owner", {30'd0, i_rvalid, d_rvalid}, {30'd0, e.instr, ~e.instr});
        check("rv_data", e.instr ? i_rdata : d_rdata, e.data);
      end
    end
  end

  typedef struct {
    logic          i_req, d_req, d_we;
    logic [BW-1:0] be;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd;
    logic          e_ig, e_dg, e_en, e_we, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;
  } vec_t;

  task automatic idle();
    i_req = 0; d_req = 0; d_we = 0; d_be = '1; i_addr = '0; d_addr = '0; d_wdata = '0;
`ifdef KTC32_LOADER_EN
    l_req = 0; l_addr = '0; l_wdata = '0;
`endif
  endtask

  vec_t  vt[7];
  string pat;
  logic [1:0] exp_g;

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'hA500_0000 | a;
    mem[14'h0010] = 32'hDEAD_BEEF;
    idle();

    // Reset held with a pending load request
    reset = 1; d_req = 1; d_addr = 14'h0060;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rel_d_gnt", {31'd0, d_gnt}, 32'd1);
    push_exp(1'b0, 32'hA500_0060);
    @(posedge clk); #1;
    idle();
    @(negedge clk);

    //          ireq dreq we  be     ia       da       wd            ig dg en we rv addr     rdata
    vt[0] = '{1, 0, 0, 4'hF, 14'h10, 14'h00, 32'h0,        1, 0, 1, 0, 0, 14'h10, 32'hDEAD_BEEF};
    vt[1] = '{0, 1, 0, 4'hF, 14'h00, 14'h11, 32'h0,        0, 1, 1, 0, 1, 14'h11, 32'hA500_0011};
    vt[2] = '{0, 1, 1, 4'h3, 14'h00, 14'h20, 32'h1234_5678, 0, 1, 1, 1, 1, 14'h20, 32'h0};
    vt[3] = '{0, 1, 0, 4'hF, 14'h00, 14'h20, 32'h0,        0, 1, 1, 0, 0, 14'h20, 32'hA500_5678};
    vt[4] = '{0, 0, 0, 4'hF, 14'h00, 14'h00, 32'h0,        0, 0, 0, 0, 1, 14'h00, 32'h0};
    vt[5] = '{1, 1, 0, 4'hF, 14'h31, 14'h30, 32'h0,        0, 1, 1, 0, 0, 14'h30, 32'hA500_0030};
    vt[6] = '{1, 0, 0, 4'hF, 14'h31, 14'h00, 32'h0,        1, 0, 1, 0, 1, 14'h31, 32'hA500_0031};

    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      i_req = vt[k].i_req; d_req = vt[k].d_req; d_we = vt[k].d_we; d_be = vt[k].be;
      i_addr = vt[k].ia; d_addr = vt[k].da; d_wdata = vt[k].wd;
      @(negedge clk);
      check($sformatf("v%0d_gnt", k), {30'd0, i_gnt, d_gnt}, {30'd0, vt[k].e_ig, vt[k].e_dg});
      check($sformatf("v%0d_en_we", k), {30'd0, ram_en, ram_we}, {30'd0, vt[k].e_en, vt[k].e_we});
      check($sformatf("v%0d_rv_prev", k), {31'd0, i_rvalid | d_rvalid}, {31'd0, vt[k].e_rv});
      if (vt[k].e_en) check($sformatf("v%0d_addr", k), {18'd0, ram_addr}, {18'd0, vt[k].e_addr});
      if (vt[k].e_en && !vt[k].e_we) push_exp(vt[k].e_ig, vt[k].e_rdata);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);

    // Contention with both requests held continuously
    pat = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      i_req = 1; i_addr = 14'h41; d_req = 1; d_we = 0; d_addr = 14'(14'h50 + k);
      @(negedge clk);
      exp_g = (pat[k] == "I") ? 2'b10 : 2'b01;
      check($sformatf("cont%0d", k), {30'd0, i_gnt, d_gnt}, {30'd0, exp_g});
      if (i_gnt) push_exp(1'b1, 32'hA500_0041);
      else if (d_gnt) push_exp(1'b0, 32'hA500_0050 + k);
    end
    @(posedge clk); #1;
    idle();
    repeat (2) @(negedge clk);

    // Reset pulse while a granted load is in flight: its rvalid must vanish
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 14'h70;
    @(negedge clk);
    check("rr_d_gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    idle();
    reset = 1;
    @(negedge clk);
    check("rr_rvalid_in_rst", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rr_rvalid_after", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    @(negedge clk);
    check("rr_rvalid_after2", {30'd0, i_rvalid, d_rvalid}, 32'd0);

`ifdef KTC32_LOADER_EN
    @(posedge clk); #1;
    l_req = 1; l_addr = 14'h80; l_wdata = 32'hCAFE_F00D;
    i_req = 1; i_addr = 14'h81; d_req = 1; d_we = 0; d_be = 4'h1; d_addr = 14'h82;
    @(negedge clk);
    check("ld_gnt", {29'd0, l_gnt, i_gnt, d_gnt}, 32'd4);
    check("ld_we_be", {27'd0, ram_we, ram_be}, {27'd0, 1'b1, 4'hF});
    check("ld_addr", {18'd0, ram_addr}, 32'h80);
    @(posedge clk); #1;
    idle();
    d_req = 1; d_addr = 14'h80;
    @(negedge clk);
    check("ld_rv_none", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    push_exp(1'b0, 32'hCAFE_F00D);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
`endif

    repeat (3) @(posedge clk);
    #4;
    check("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
